// File: rtl/drp_reconf_seq_if.sv
// DRP bus between the reconfiguration sequencer (master) and the PLL DRP port (slave).
interface drp_reconf_seq_if;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;

  modport master (output DADDR, DEN, DWE, DI, input DO, DRDY);
  modport slave  (input DADDR, DEN, DWE, DI, output DO, DRDY);
endinterface

// File: rtl/drp_reconf_seq.sv
// PLL DRP reconfiguration sequencer: read-modify-write of a software-loaded table under PLL reset.
// Optional watchdog on DRDY/LOCKED waits is enabled with DRP_RECONF_SEQ_TIMEOUT_EN.
module drp_reconf_seq #(
  parameter int DEPTH    = 32,
  parameter int IDX_W    = 5,
  parameter int RST_HOLD = 4
`ifdef DRP_RECONF_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic                DCLK,
  input  logic                RST_N,
  input  logic                CFG_WE,
  input  logic [IDX_W-1:0]    CFG_IDX,
  input  logic [6:0]          CFG_ADDR,
  input  logic [15:0]         CFG_MASK,
  input  logic [15:0]         CFG_DATA,
  input  logic [IDX_W:0]      CFG_LEN,
  input  logic                SSTEP,
  input  logic                LOCKED,
  drp_reconf_seq_if.master    drp,
  output logic                PLL_RST,
  output logic                BUSY,
  output logic                SRDY,
  output logic                ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT_RD, S_WR, S_WAIT_WR, S_HOLD, S_WAIT_LOCK
  } state_t;

  localparam int HC_W = $clog2(RST_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RST_HOLD - 1);
  localparam logic [IDX_W:0]  DEPTH_L   = (IDX_W+1)'(DEPTH);

  state_t state, state_n;

  logic [38:0]      tbl [DEPTH];
  logic [IDX_W:0]   idx, len, idx_inc, len_clamped;
  logic [15:0]      val;
  logic [HC_W-1:0]  hold_cnt;
  logic             ovr_valid;
  logic [IDX_W-1:0] ovr_idx;
  logic [38:0]      ovr_entry;
  logic [38:0]      cur_entry;
  logic             accept, cfg_wr, in_xfer, timeout_hit;
  logic             den, dwe;

  assign accept      = SSTEP && (state == S_IDLE);
  assign cfg_wr      = CFG_WE && (state == S_IDLE);
  assign idx_inc     = idx + 1'b1;
  assign len_clamped = (CFG_LEN > DEPTH_L) ? DEPTH_L : CFG_LEN;
  assign in_xfer     = (state == S_RD) || (state == S_WAIT_RD) ||
                       (state == S_WR) || (state == S_WAIT_WR);

  // A write landing in the start cycle must not affect this run, so the old entry is kept aside.
  assign cur_entry = (ovr_valid && (ovr_idx == idx[IDX_W-1:0])) ? ovr_entry
                                                                : tbl[idx[IDX_W-1:0]];

  always_ff @(posedge DCLK) begin
    if (cfg_wr) tbl[CFG_IDX] <= {CFG_ADDR, CFG_MASK, CFG_DATA};
  end

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    den     = 1'b0;
    dwe     = 1'b0;
    case (state)
      S_IDLE:      if (SSTEP) state_n = (len_clamped == '0) ? S_HOLD : S_RD;
      S_RD: begin
        den     = 1'b1;
        state_n = S_WAIT_RD;
      end
      S_WAIT_RD:   if (drp.DRDY) state_n = S_WR;
      S_WR: begin
        den     = 1'b1;
        dwe     = 1'b1;
        state_n = S_WAIT_WR;
      end
      S_WAIT_WR:   if (drp.DRDY) state_n = (idx_inc == len) ? S_HOLD : S_RD;
      S_HOLD:      if (hold_cnt == HOLD_LAST) state_n = S_WAIT_LOCK;
      S_WAIT_LOCK: if (LOCKED) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
    if (timeout_hit) state_n = S_IDLE;
  end

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      idx       <= '0;
      len       <= '0;
      val       <= '0;
      hold_cnt  <= '0;
      PLL_RST   <= 1'b0;
      SRDY      <= 1'b0;
      ovr_valid <= 1'b0;
      ovr_idx   <= '0;
      ovr_entry <= '0;
    end else begin
      SRDY     <= (state == S_WAIT_LOCK) && LOCKED;
      hold_cnt <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
      if (accept) begin
        len       <= len_clamped;
        idx       <= '0;
        PLL_RST   <= 1'b1;
        ovr_valid <= CFG_WE;
        ovr_idx   <= CFG_IDX;
        ovr_entry <= tbl[CFG_IDX];
      end
      if ((state == S_WAIT_RD) && drp.DRDY)
        val <= (drp.DO & cur_entry[31:16]) | cur_entry[15:0];
      if ((state == S_WAIT_WR) && drp.DRDY) idx <= idx_inc;
      if (((state == S_HOLD) && (hold_cnt == HOLD_LAST)) || timeout_hit) PLL_RST <= 1'b0;
    end
  end

`ifdef DRP_RECONF_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            in_wait, wait_evt;

  assign in_wait     = (state == S_WAIT_RD) || (state == S_WAIT_WR) || (state == S_WAIT_LOCK);
  assign wait_evt    = (state == S_WAIT_LOCK) ? LOCKED : drp.DRDY;
  assign timeout_hit = in_wait && !wait_evt && (wd_cnt == WD_LAST);

  // Watchdog restarts on every state change so each wait gets the full budget.
  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_cnt <= '0;
      ERR    <= 1'b0;
    end else begin
      if (state_n != state) wd_cnt <= '0;
      else if (in_wait)     wd_cnt <= wd_cnt + 1'b1;
      if (accept)           ERR <= 1'b0;
      else if (timeout_hit) ERR <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign ERR         = 1'b0;
`endif

  assign BUSY      = (state != S_IDLE);
  assign drp.DEN   = den;
  assign drp.DWE   = dwe;
  assign drp.DADDR = in_xfer ? cur_entry[38:32] : 7'd0;
  assign drp.DI    = val;

endmodule

// File: tb/tb_drp_reconf_seq.sv
// Scoreboard bench for drp_reconf_seq: a DRP slave with register memory, a PLL lock model and a monitor.
module tb_drp_reconf_seq;
  localparam int DEPTH    = 32;
  localparam int IDX_W    = 5;
  localparam int RST_HOLD = 4;
`ifdef DRP_RECONF_SEQ_TIMEOUT_EN
  localparam int TIMEOUT  = 16;
`endif

  logic             DCLK = 1'b0;
  logic             RST_N = 1'b1;
  logic             CFG_WE = 1'b0;
  logic [IDX_W-1:0] CFG_IDX = '0;
  logic [6:0]       CFG_ADDR = '0;
  logic [15:0]      CFG_MASK = '0;
  logic [15:0]      CFG_DATA = '0;
  logic [IDX_W:0]   CFG_LEN = '0;
  logic             SSTEP = 1'b0;
  logic             LOCKED = 1'b0;
  logic             PLL_RST, BUSY, SRDY, ERR;

  drp_reconf_seq_if drp_bus ();

  drp_reconf_seq #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .RST_HOLD(RST_HOLD)
`ifdef DRP_RECONF_SEQ_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .DCLK(DCLK), .RST_N(RST_N), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
    .CFG_ADDR(CFG_ADDR), .CFG_MASK(CFG_MASK), .CFG_DATA(CFG_DATA),
    .CFG_LEN(CFG_LEN), .SSTEP(SSTEP), .LOCKED(LOCKED), .drp(drp_bus),
    .PLL_RST(PLL_RST), .BUSY(BUSY), .SRDY(SRDY), .ERR(ERR)
  );

  always #5 DCLK = ~DCLK;

  // kind: 0 = DRP read, 1 = DRP write, 2 = completion pulse
  typedef struct {
    int          kind;
    logic [6:0]  addr;
    logic [15:0] data;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [38:0] model_tbl [DEPTH];
  logic [15:0] slave_mem [128];
  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0;
  int slave_lat = 2, lock_delay = 5;
  int exp_hold_exact = -1;
  int wr_seen = 0;
  bit no_drdy = 1'b0, outstanding = 1'b0, skip_hold = 1'b0;

  always @(posedge DCLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DRP slave: register file answered after slave_lat cycles, one access at a time.
  initial begin
    int          cnt;
    bit          s_wr;
    logic [6:0]  s_addr;
    logic [15:0] s_di;
    cnt = 0; s_wr = 0; s_addr = '0; s_di = '0;
    drp_bus.DRDY = 1'b0;
    drp_bus.DO   = '0;
    forever begin
      @(negedge DCLK);
      drp_bus.DRDY = 1'b0;
      if (!RST_N) outstanding = 1'b0;
      else if (drp_bus.DEN) begin
        check("den_before_drdy", {31'd0, outstanding}, 32'd0);
        outstanding = 1'b1;
        cnt    = slave_lat;
        s_wr   = drp_bus.DWE;
        s_addr = drp_bus.DADDR;
        s_di   = drp_bus.DI;
      end else if (outstanding && !no_drdy) begin
        cnt--;
        if (cnt == 0) begin
          drp_bus.DO = s_wr ? 16'($urandom) : slave_mem[s_addr];
          if (s_wr) slave_mem[s_addr] = s_di;
          drp_bus.DRDY = 1'b1;
          outstanding  = 1'b0;
        end
      end
    end
  end

  // PLL model: LOCKED rises lock_delay cycles after reset is released.
  initial begin
    int lc;
    lc = 0;
    forever begin
      @(negedge DCLK);
      if (PLL_RST || !RST_N) begin
        LOCKED = 1'b0;
        lc = 0;
      end else if (!LOCKED) begin
        lc++;
        if (lc >= lock_delay) LOCKED = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a DRP access or a done pulse.
  initial begin
    bit   prev_den, prev_srdy, prev_rst;
    int   hold;
    exp_t e;
    prev_den = 0; prev_srdy = 0; prev_rst = 0; hold = 0;
    forever begin
      @(negedge DCLK);
      if (RST_N) begin
        if (drp_bus.DEN) begin
          if (prev_den) check("den_one_cycle", {31'd0, prev_den}, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_den", {25'd0, drp_bus.DADDR}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("drp_kind", {30'd0, drp_bus.DEN, drp_bus.DWE},
                  (e.kind == 0) ? 32'd2 : (e.kind == 1) ? 32'd3 : 32'd0);
            check("drp_addr", {25'd0, drp_bus.DADDR}, {25'd0, e.addr});
            if (e.kind == 1) begin
              check("drp_di", {16'd0, drp_bus.DI}, {16'd0, e.data});
              wr_seen++;
            end
          end
        end
        if (SRDY) begin
          if (prev_srdy) check("srdy_one_cycle", {31'd0, prev_srdy}, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_srdy", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("done_order", e.kind, 32'd2);
            check("latency", cyc - start_cyc, e.lat);
            check("busy_at_done", {31'd0, BUSY}, 32'd0);
          end
        end
        if (!PLL_RST) begin
          if (prev_rst && !skip_hold) begin
            if (exp_hold_exact >= 0) check("hold_exact", hold, exp_hold_exact);
            else                     check("hold_min", {31'd0, hold >= RST_HOLD}, 32'd1);
          end
          hold = 0;
        end else if (drp_bus.DEN) hold = 0;
        else hold++;
      end
      prev_den  = drp_bus.DEN;
      prev_srdy = SRDY;
      prev_rst  = PLL_RST;
    end
  end

  task automatic write_entry(input int idx, input logic [6:0] a, input logic [15:0] m,
                             input logic [15:0] d, input bit ignored);
    @(negedge DCLK);
    CFG_WE = 1'b1; CFG_IDX = IDX_W'(idx); CFG_ADDR = a; CFG_MASK = m; CFG_DATA = d;
    if (!ignored) model_tbl[idx] = {a, m, d};
    @(negedge DCLK);
    CFG_WE = 1'b0;
  endtask

  // Issue SSTEP and push the reference RMW sequence computed from the model table and register image.
  task automatic apply_stimulus(input int len_req, input int lat, input int ldly,
                                input bit we = 0, input int widx = 0,
                                input logic [38:0] went = '0, input bit expect_to = 0);
    logic [15:0] m [128];
    logic [38:0] ent;
    logic [15:0] v;
    int          n;
    exp_t        e;
    @(negedge DCLK);
    slave_lat  = lat;
    lock_delay = ldly;
    skip_hold  = expect_to;
    n = (len_req > DEPTH) ? DEPTH : len_req;
    exp_hold_exact = (n == 0) ? RST_HOLD : -1;
    m = slave_mem;
    for (int i = 0; i < n; i++) begin
      ent = model_tbl[i];
      e.kind = 0; e.addr = ent[38:32]; e.data = '0; e.lat = 0;
      exp_q.push_back(e);
      if (expect_to) break;
      v = (m[ent[38:32]] & ent[31:16]) | ent[15:0];
      m[ent[38:32]] = v;
      e.kind = 1; e.data = v;
      exp_q.push_back(e);
    end
    if (!expect_to) begin
      e.kind = 2; e.addr = '0; e.data = '0;
      e.lat  = 2 * n * (lat + 1) + RST_HOLD + ldly + 1;
      exp_q.push_back(e);
    end
    SSTEP = 1'b1;
    CFG_LEN = (IDX_W+1)'(len_req);
    if (we) begin
      CFG_WE = 1'b1; CFG_IDX = IDX_W'(widx);
      CFG_ADDR = went[38:32]; CFG_MASK = went[31:16]; CFG_DATA = went[15:0];
      model_tbl[widx] = went;
    end
    start_cyc = cyc;
    @(negedge DCLK);
    SSTEP = 1'b0;
    CFG_WE = 1'b0;
  endtask

  task automatic check_output(input string tag, input bit busy, input bit pll, input bit err);
    check({tag, "_busy"},    {31'd0, BUSY},    {31'd0, busy});
    check({tag, "_pll_rst"}, {31'd0, PLL_RST}, {31'd0, pll});
    check({tag, "_err"},     {31'd0, ERR},     {31'd0, err});
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge DCLK);
    check({tag, "_complete"}, exp_q.size(), 32'd0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      skip_hold = 1'b1;
      @(negedge DCLK); RST_N = 1'b0;
      @(negedge DCLK); RST_N = 1'b1;
    end
    repeat (2) @(negedge DCLK);
    check_output(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_daddr"}, {25'd0, drp_bus.DADDR}, 32'd0);
    check({tag, "_den"},   {31'd0, drp_bus.DEN},   32'd0);
    check({tag, "_dwe"},   {31'd0, drp_bus.DWE},   32'd0);
    check({tag, "_di"},    {16'd0, drp_bus.DI},    32'd0);
    check({tag, "_srdy"},  {31'd0, SRDY},          32'd0);
    check_output(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 128; i++) slave_mem[i] = 16'($urandom);
    #1 RST_N = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge DCLK);
    RST_N = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      write_entry(i, 7'($urandom), 16'($urandom), 16'($urandom), 1'b0);

    $display("[TB] single entry RMW");
    write_entry(0, 7'h08, 16'hF000, 16'h0041, 1'b0);
    slave_mem[8] = 16'hABCD;
    apply_stimulus(1, 2, 5);
    wait_done("single", 500);

    $display("[TB] three entries");
    for (int i = 0; i < 3; i++)
      write_entry(i, 7'(8'h14 + i), 16'($urandom), 16'($urandom), 1'b0);
    apply_stimulus(3, 1, 3);
    wait_done("three", 500);

    $display("[TB] zero length");
    apply_stimulus(0, 2, 4);
    wait_done("len0", 500);

    $display("[TB] start and table write while busy");
    apply_stimulus(4, 3, 2);
    repeat (3) @(negedge DCLK);
    SSTEP = 1'b1;
    @(negedge DCLK);
    SSTEP = 1'b0;
    write_entry(1, 7'h7F, 16'h0000, 16'hFFFF, 1'b1);
    wait_done("busy_ign", 500);
    apply_stimulus(4, 1, 1);
    wait_done("busy_ign2", 500);

    $display("[TB] table write in the start cycle");
    apply_stimulus(2, 2, 3, 1'b1, 0, {7'h33, 16'h00FF, 16'h1200});
    wait_done("collide", 500);
    apply_stimulus(2, 1, 2);
    wait_done("collide2", 500);

    $display("[TB] reset during WAIT_WR");
    apply_stimulus(3, 3, 2);
    w0 = wr_seen;
    for (int i = 0; i < 200 && wr_seen == w0; i++) @(negedge DCLK);
    check("reached_wr", {31'd0, wr_seen > w0}, 32'd1);
    @(posedge DCLK);
    #2;
    skip_hold = 1'b1;
    RST_N = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    repeat (5) @(negedge DCLK);
    RST_N = 1'b1;
    repeat (20) @(negedge DCLK);
    check_output("post_rst", 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized sequences");
    for (int it = 0; it < 10; it++) begin
      repeat (2)
        write_entry($urandom_range(0, DEPTH-1), 7'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      apply_stimulus((it == 9) ? 40 : $urandom_range(0, 8), $urandom_range(1, 4), $urandom_range(1, 6));
      wait_done("rand", 3000);
    end

`ifdef DRP_RECONF_SEQ_TIMEOUT_EN
    $display("[TB] watchdog");
    no_drdy = 1'b1;
    apply_stimulus(1, 1, 2, 1'b0, 0, '0, 1'b1);
    for (int i = 0; i < 200 && !ERR; i++) @(negedge DCLK);
    check("err_cycle", cyc - start_cyc, TIMEOUT + 2);
    check_output("timeout", 1'b0, 1'b0, 1'b1);
    check("timeout_queue", exp_q.size(), 32'd0);
    repeat (10) @(negedge DCLK);
    no_drdy = 1'b0;
    outstanding = 1'b0;
    apply_stimulus(0, 1, 2);
    check("err_cleared", {31'd0, ERR}, 32'd0);
    wait_done("after_to", 500);
`endif

    check("final_queue", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/drp_reconf_seq.md
Name: drp_reconf_seq

Overview:
- DRP master sitting directly upstream of the PLL dynamic-reconfiguration port; drives its DADDR/DEN/DWE/DI and consumes its DO/DRDY.
- Holds a small table of (address, mask, data) entries loaded by software.
- On a start strobe, holds the PLL in reset and performs a read-modify-write of every table entry over DRP.
- Then releases the PLL reset, waits for LOCKED and reports completion.

Parameters:
- DEPTH, 32, number of table entries (power of two).
- IDX_W, 5, log2(DEPTH).
- RST_HOLD, 4, minimum DCLK cycles PLL_RST stays high after the last write.
- TIMEOUT, 1024, watchdog limit in DCLK cycles (used only with the optional feature).

Ports:
- DCLK, in, 1, sole clock; DRP clock.
- RST_N, in, 1, asynchronous active-low reset.
- CFG_WE, in, 1, table write strobe.
- CFG_IDX, in, IDX_W, table entry index.
- CFG_ADDR, in, 7, DRP address for the entry.
- CFG_MASK, in, 16, bits at 1 keep the read value.
- CFG_DATA, in, 16, bits ORed into the masked value.
- CFG_LEN, in, IDX_W+1, number of valid entries (0..DEPTH); sampled at start.
- SSTEP, in, 1, start strobe.
- LOCKED, in, 1, PLL lock indicator.
- DADDR, out, 7, DRP address.
- DEN, out, 1, DRP enable.
- DWE, out, 1, DRP write enable.
- DI, out, 16, DRP write data.
- DO, in, 16, DRP read data.
- DRDY, in, 1, DRP ready.
- PLL_RST, out, 1, reset to PLL.
- BUSY, out, 1, sequence in progress.
- SRDY, out, 1, one-cycle done pulse.
- ERR, out, 1, sticky error flag.

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE, DADDR=0, DEN=0, DWE=0, DI=0, PLL_RST=0, BUSY=0, SRDY=0, ERR=0, entry index=0. Table contents are not reset.
- Reset mid-sequence aborts immediately. PLL_RST drops to 0 and the PLL is left partially configured. Software restarts the sequence.
- Table write: on CFG_WE in any state except BUSY, entry[CFG_IDX] <= {CFG_ADDR, CFG_MASK, CFG_DATA} next edge. CFG_WE while BUSY is ignored.
- States:
  - IDLE: BUSY=0. SSTEP=1 latches len=CFG_LEN, idx=0, sets PLL_RST=1, BUSY=1, then goes to RD, or to HOLD if len=0.
  - RD: DEN=1, DWE=0, DADDR=entry[idx].addr for exactly one cycle, then WAIT_RD.
  - WAIT_RD: DEN=0. On DRDY=1, capture val=(DO & mask) | data, then WR.
  - WR: DEN=1, DWE=1, DI=val, DADDR unchanged for exactly one cycle, then WAIT_WR.
  - WAIT_WR: DEN=0, DWE=0. On DRDY=1, idx<=idx+1. If idx+1==len go to HOLD, else go to RD.
  - HOLD: PLL_RST=1 for RST_HOLD cycles (counter), then PLL_RST<=0 and go to WAIT_LOCK.
  - WAIT_LOCK: on LOCKED=1, SRDY=1 for one cycle, BUSY<=0, then IDLE.
- DRDY handling: DRDY is only evaluated in WAIT_RD/WAIT_WR, starting the cycle after the DEN pulse. DRDY seen in any other state is ignored.
- DEN is never asserted twice without an intervening DRDY.
- SSTEP while BUSY is ignored. SSTEP and CFG_WE in the same cycle in IDLE: the write is performed, and the sequence uses the pre-write table contents for that index.
- Latency, len entries, DRDY after k cycles: 2*len*(k+1) + RST_HOLD + lock wait + 1 cycles from SSTEP to SRDY.
- Index and len arithmetic are IDX_W+1 bits; no wrap occurs since len<=DEPTH. CFG_LEN>DEPTH is clamped to DEPTH.
- ERR: cleared on SSTEP acceptance. Set only by the optional feature.

Optional Feature:
- Macro: DRP_RECONF_SEQ_TIMEOUT_EN.
- Enabled: a watchdog counts cycles in WAIT_RD, WAIT_WR and WAIT_LOCK. It resets on each state entry.
- On reaching TIMEOUT without DRDY/LOCKED: ERR<=1, DEN=DWE=0, PLL_RST<=0, BUSY<=0, IDLE, no SRDY.
- Disabled: waits indefinitely, ERR is tied 0, and no counter logic is generated.

Test Plan:
- Load entry0={0x08, 0xF000, 0x0041}, len=1. Slave returns DO=0xABCD with DRDY 2 cycles after DEN, then SSTEP. Expect a read at 0x08, then a write DI=0xA041 at 0x08, PLL_RST high ≥RST_HOLD cycles, LOCKED raised 5 cycles later, single SRDY pulse, BUSY low.
- len=3 at addresses 0x14, 0x15, 0x16. Expect six DEN pulses in the order R14, W14, R15, W15, R16, W16, each DEN one cycle wide, with no DEN before the prior DRDY.
- len=0 with SSTEP. Expect no DEN, PLL_RST high exactly RST_HOLD cycles, then SRDY after LOCKED.
- SSTEP and CFG_WE issued during BUSY. Expect no restart, the table unchanged, and the original sequence completing normally.
- RST_N pulled low during WAIT_WR. Expect all outputs at reset values immediately, without waiting for a clock edge, and no SRDY.
- With DRP_RECONF_SEQ_TIMEOUT_EN and TIMEOUT=16, the slave never asserts DRDY. Expect ERR=1 at cycle 16 of WAIT_RD, PLL_RST=0, BUSY=0, no SRDY. The next SSTEP clears ERR.
